// File: rtl/matrix_frame_sequencer.sv
// Frame sequencer for an N x N cell buffer: fills one frame row-major from the
// input stream, then drains it row-major or column-major on the output stream.
module matrix_frame_sequencer #(
  parameter int unsigned DW = 4,
  parameter int unsigned N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          transpose,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned L  = $clog2(N);
  localparam int unsigned CW = 2 * L;
  localparam logic [CW-1:0] LAST = CW'(N * N - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          xpose_q;
  logic          done_q;
  logic [DW-1:0] mem_q [N*N];

  logic          wr_en;
  logic [CW-1:0] wr_addr;
  logic [CW-1:0] rd_addr;

  always_comb begin
    wr_en   = in_valid && (state_q != DRAIN) && !abort;
    wr_addr = (state_q == IDLE) ? '0 : cnt_q;
    // Swapping the row and column halves of the index gives column-major order.
    rd_addr = xpose_q ? {cnt_q[L-1:0], cnt_q[CW-1:L]} : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xpose_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (in_valid) begin
              xpose_q <= transpose;
              cnt_q   <= CW'(1);
              state_q <= FILL;
            end
          end
          FILL: begin
            if (in_valid) begin
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == LAST) state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (out_ready) begin
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == LAST) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= in_data;
  end

  always_comb begin
    in_ready   = (state_q != DRAIN);
    out_valid  = (state_q == DRAIN);
    out_last   = (state_q == DRAIN) && (cnt_q == LAST);
    busy       = (state_q != IDLE);
    frame_done = done_q;
    out_data   = mem_q[rd_addr];
  end

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Bench for matrix_frame_sequencer: directed frames plus random traffic, checked
// against a word-count model of the frame buffer.
module tb_matrix_frame_sequencer;

  localparam int DW = 4;
  localparam int N  = 4;
  localparam int NN = N * N;

  logic          clk;
  logic          rst;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          transpose;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // Model: words accepted into the current frame, words drained, frame contents.
  int          m_in;
  int          m_out;
  bit          m_xp;
  bit          m_done;
  int unsigned mframe [NN];

  matrix_frame_sequencer #(.DW(DW), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .transpose  (transpose),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in   = 0;
    m_out  = 0;
    m_xp   = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit iv, input int unsigned d, input bit tr, input bit ordy, input bit ab);
    m_done = 1'b0;
    if (ab) begin
      m_in  = 0;
      m_out = 0;
    end else if (m_in < NN) begin
      if (iv) begin
        if (m_in == 0) m_xp = tr;
        mframe[m_in] = d;
        m_in++;
      end
    end else if (ordy) begin
      m_out++;
      if (m_out == NN) begin
        m_in   = 0;
        m_out  = 0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    int idx;
    bit ev;
    ev = (m_in == NN);
    check_eq("in_ready", in_ready, (m_in < NN));
    check_eq("out_valid", out_valid, ev);
    check_eq("busy", busy, (m_in != 0));
    check_eq("frame_done", frame_done, m_done);
    check_eq("out_last", out_last, ev && (m_out == NN - 1));
    if (ev) begin
      idx = m_xp ? ((m_out % N) * N + m_out / N) : m_out;
      check_eq("out_data", out_data, mframe[idx]);
    end
  endtask

  task automatic cycle(input bit iv, input int unsigned d, input bit tr, input bit ordy, input bit ab);
    in_valid  = iv;
    in_data   = DW'(d);
    transpose = tr;
    out_ready = ordy;
    abort     = ab;
    @(posedge clk);
    model_step(iv, d & ((1 << DW) - 1), tr, ordy, ab);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic fill_frame(input bit rev, input bit tr, input bit gaps, input bit tog);
    int i;
    int c;
    bit v;
    bit t;
    i = 0;
    c = 0;
    while (i < NN) begin
      v = !(gaps && (c % 3 == 2));
      t = (tog && i > 0) ? bit'($urandom_range(0, 1)) : tr;
      cycle(v, rev ? (NN - 1 - i) : i, t, 1'b1, 1'b0);
      if (v) i++;
      c++;
    end
  endtask

  task automatic drain_frame(input bit stalls, input bit iv, input int unsigned d);
    for (int k = 0; k < NN; k++) begin
      if (stalls && (k == 5 || k == NN - 1)) begin
        cycle(iv, d, 1'b0, 1'b0, 1'b0);
        cycle(iv, d, 1'b0, 1'b0, 1'b0);
      end
      cycle(iv, d, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    transpose = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Row-major frame
    fill_frame(1'b0, 1'b0, 1'b0, 1'b0);
    drain_frame(1'b0, 1'b0, 0);
    idle(2);

    // Transposed frame, transpose toggled randomly during fill
    fill_frame(1'b0, 1'b1, 1'b0, 1'b1);
    drain_frame(1'b0, 1'b0, 0);
    idle(2);

    // Flow control on both sides
    fill_frame(1'b0, 1'b0, 1'b1, 1'b0);
    drain_frame(1'b1, 1'b0, 0);
    idle(1);

    // Back-to-back: B's first word is presented throughout A's drain
    fill_frame(1'b0, 1'b0, 1'b0, 1'b0);
    drain_frame(1'b0, 1'b1, NN - 1);
    check_eq("b2b_frame_done", frame_done, 1'b1);
    fill_frame(1'b1, 1'b0, 1'b0, 1'b0);
    drain_frame(1'b0, 1'b0, 0);
    idle(2);

    // Abort on the 8th accept, then a fresh frame
    for (int i = 0; i < 7; i++) cycle(1'b1, i + 3, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 7, 1'b0, 1'b1, 1'b1);
    idle(1);
    fill_frame(1'b0, 1'b0, 1'b0, 1'b0);
    drain_frame(1'b0, 1'b0, 0);
    idle(2);

    // Abort during drain with out_ready high
    fill_frame(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    check_eq("abort_drain_valid", out_valid, 1'b0);
    idle(2);
    fill_frame(1'b0, 1'b0, 1'b0, 1'b0);
    drain_frame(1'b0, 1'b0, 0);
    idle(2);

    // Asynchronous reset between edges at drain index 6
    fill_frame(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    fill_frame(1'b0, 1'b0, 1'b0, 1'b0);
    drain_frame(1'b0, 1'b0, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 8, $urandom, bit'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0);
    end
    idle(NN + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
